// File: rtl/pcileech_rx128_pkg.sv
// Shared definitions for the 128-bit RX alignment path: core user-bit layout,
// decoded user struct, alignment modes and the DW keep helper.
package pcileech_rx128_pkg;

  localparam int RXU_BAR_LO  = 2;
  localparam int RXU_BAR_HI  = 8;
  localparam int RXU_SOF_DW2 = 13;
  localparam int RXU_SOF     = 14;
  localparam int RXU_EOF_LO  = 19;
  localparam int RXU_EOF_HI  = 20;
  localparam int RXU_EOF     = 21;

  typedef struct packed {
    logic       sof;
    logic       sof_dw2;
    logic       eof;
    logic [1:0] eof_dw;
    logic [6:0] bar;
  } rx_user_dec_t;

  typedef enum logic [1:0] {
    MODE_IDLE    = 2'd0,
    MODE_ALIGNED = 2'd1,
    MODE_SHIFTED = 2'd2,
    MODE_DROP    = 2'd3
  } rx_mode_e;

  // sof_dw2 only qualifies a start that is actually flagged by sof
  function automatic rx_user_dec_t rx_user_decode(input logic [21:0] u);
    rx_user_dec_t d;
    d.sof     = u[RXU_SOF];
    d.sof_dw2 = u[RXU_SOF] & u[RXU_SOF_DW2];
    d.eof     = u[RXU_EOF];
    d.eof_dw  = u[RXU_EOF_HI:RXU_EOF_LO];
    d.bar     = u[RXU_BAR_HI:RXU_BAR_LO];
    return d;
  endfunction

  function automatic logic [3:0] keep_from_dw(input logic [1:0] idx);
    logic [3:0] k;
    case (idx)
      2'd0:    k = 4'h1;
      2'd1:    k = 4'h3;
      2'd2:    k = 4'h7;
      default: k = 4'hF;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/pcileech_axis128_oreg.sv
// Output register slice for the aligned TLP stream; loads a new beat (or a
// bubble) whenever the slot is empty or the sink takes the current beat.
module pcileech_axis128_oreg (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  input  logic [3:0]   in_keep,
  input  logic         in_last,
  input  logic [8:0]   in_user,
  input  logic         m_tready,
  output logic         adv,
  output logic         m_tvalid,
  output logic [127:0] m_tdata,
  output logic [3:0]   m_tkeepdw,
  output logic         m_tlast,
  output logic [8:0]   m_tuser
);

  assign adv = !m_tvalid | m_tready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tkeepdw <= '0;
      m_tlast   <= 1'b0;
      m_tuser   <= '0;
    end else if (adv) begin
      m_tvalid  <= in_valid;
      m_tdata   <= in_data;
      m_tkeepdw <= in_keep;
      m_tlast   <= in_last;
      m_tuser   <= in_user;
    end
  end

endmodule

// File: rtl/pcileech_tlps128_rx_align.sv
// Realigns 128-bit PCIe core RX beats so every TLP starts at DW0, with
// BAR filtering, per-beat DW keep and a saturating protocol-error counter.
module pcileech_tlps128_rx_align
  import pcileech_rx128_pkg::*;
#(
  parameter int         ERR_CNT_W       = 16,
  parameter logic [6:0] BAR_ACCEPT_MASK = 7'h7F
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [127:0]         rx_data,
  input  logic [21:0]          rx_user,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [127:0]         m_tdata,
  output logic [3:0]           m_tkeepdw,
  output logic                 m_tvalid,
  output logic                 m_tlast,
  output logic [8:0]           m_tuser,
  input  logic                 m_tready,
  output logic                 m_has_data,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  rx_mode_e     mode, mode_n;
  logic [63:0]  carry, carry_n;
  logic [6:0]   carry_bar, carry_bar_n;
  logic         first_pend, first_pend_n;
  logic         flush_pend, flush_pend_n;
  logic         flush_k0, flush_k0_n;
  logic         carry_v;
  logic         adv, beat, start, err;
  logic         sof0, sof2;
  rx_user_dec_t dec;

  logic         e_valid, e_first, e_last;
  logic [127:0] e_data;
  logic [3:0]   e_keep;
  logic [6:0]   e_bar;

  logic unused_user_bits;
  assign unused_user_bits = ^{rx_user[18:15], rx_user[12:9], rx_user[1:0]};

  assign dec      = rx_user_decode(rx_user);
  assign sof0     = dec.sof & !dec.sof_dw2;
  assign sof2     = dec.sof_dw2;
  assign rx_ready = adv & !flush_pend & rst_n;
  assign beat     = rx_valid & rx_ready;
  assign carry_v  = (mode == MODE_SHIFTED) | flush_pend;

  assign m_has_data = m_tvalid | carry_v;

  // carry_bar is the BAR of the TLP currently in flight, also used for aligned TLPs
  always_comb begin
    mode_n       = mode;
    carry_n      = carry;
    carry_bar_n  = carry_bar;
    first_pend_n = first_pend;
    flush_pend_n = flush_pend;
    flush_k0_n   = flush_k0;
    err          = 1'b0;
    start        = 1'b0;
    e_valid      = 1'b0;
    e_data       = rx_data;
    e_keep       = 4'hF;
    e_first      = 1'b0;
    e_last       = 1'b0;
    e_bar        = carry_bar;

    if (flush_pend) begin
      if (adv) begin
        e_valid      = 1'b1;
        e_data       = {64'h0, carry};
        e_keep       = keep_from_dw({1'b0, flush_k0});
        e_last       = 1'b1;
        flush_pend_n = 1'b0;
        mode_n       = MODE_IDLE;
      end
    end else if (beat) begin
      case (mode)
        MODE_IDLE: begin
          if (dec.sof) start = 1'b1;
          else         err   = 1'b1;
        end
        MODE_ALIGNED: begin
          if (sof0) begin
            err   = 1'b1;
            start = 1'b1;
          end else if (dec.eof) begin
            e_valid = 1'b1;
            e_keep  = keep_from_dw(dec.eof_dw);
            e_last  = 1'b1;
            mode_n  = MODE_IDLE;
            start   = sof2;
          end else if (sof2) begin
            err   = 1'b1;
            start = 1'b1;
          end else begin
            e_valid = 1'b1;
          end
        end
        MODE_SHIFTED: begin
          if (sof0) begin
            err   = 1'b1;
            start = 1'b1;
          end else begin
            e_valid      = 1'b1;
            e_data       = {rx_data[63:0], carry};
            e_first      = first_pend;
            first_pend_n = 1'b0;
            if (dec.eof && !dec.eof_dw[1]) begin
              e_keep = keep_from_dw({1'b1, dec.eof_dw[0]});
              e_last = 1'b1;
              mode_n = MODE_IDLE;
              start  = sof2;
            end else begin
              carry_n = rx_data[127:64];
              if (dec.eof) begin
                flush_pend_n = 1'b1;
                flush_k0_n   = dec.eof_dw[0];
              end
            end
          end
        end
        default: begin
          if (sof0) begin
            start = 1'b1;
          end else if (dec.eof) begin
            mode_n = MODE_IDLE;
            start  = sof2;
          end
        end
      endcase

      // A new TLP may begin after an ending TLP was emitted in the same beat
      if (start) begin
        carry_bar_n = dec.bar;
        if (|(dec.bar & ~BAR_ACCEPT_MASK)) begin
          mode_n = (sof0 && dec.eof) ? MODE_IDLE : MODE_DROP;
        end else if (sof2) begin
          carry_n      = rx_data[127:64];
          first_pend_n = 1'b1;
          mode_n       = MODE_SHIFTED;
        end else begin
          e_valid = 1'b1;
          e_data  = rx_data;
          e_first = 1'b1;
          e_bar   = dec.bar;
          e_last  = dec.eof;
          e_keep  = dec.eof ? keep_from_dw(dec.eof_dw) : 4'hF;
          mode_n  = dec.eof ? MODE_IDLE : MODE_ALIGNED;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode       <= MODE_IDLE;
      carry      <= '0;
      carry_bar  <= '0;
      first_pend <= 1'b0;
      flush_pend <= 1'b0;
      flush_k0   <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      mode       <= mode_n;
      carry      <= carry_n;
      carry_bar  <= carry_bar_n;
      first_pend <= first_pend_n;
      flush_pend <= flush_pend_n;
      flush_k0   <= flush_k0_n;
      err_pulse  <= err;
      if (err && (err_cnt != '1)) err_cnt <= err_cnt + ERR_CNT_W'(1);
    end
  end

  pcileech_axis128_oreg u_oreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (e_valid),
    .in_data   (e_data),
    .in_keep   (e_keep),
    .in_last   (e_last),
    .in_user   ({e_bar, e_last, e_first}),
    .m_tready  (m_tready),
    .adv       (adv),
    .m_tvalid  (m_tvalid),
    .m_tdata   (m_tdata),
    .m_tkeepdw (m_tkeepdw),
    .m_tlast   (m_tlast),
    .m_tuser   (m_tuser)
  );

endmodule
